// File: rtl/d_mem_ctrl.sv
// Data-memory controller: valid/ready front end over a 1-cycle synchronous RAM.
// Word-crossing accesses become two RAM beats; loads leave fully extended.
module d_mem_ctrl #(
    parameter int WORD_WIDTH       = 32,
    parameter int ADRS_WIDTH       = 32,
    parameter int MEM_DEPTH_WORDS  = 256,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADRS_WIDTH-1:0]   adrs,
    input  logic                    rden,
    input  logic                    wren,
    input  logic [WORD_WIDTH/8-1:0] byt_en,
    input  logic                    sign_ext,
    input  logic [WORD_WIDTH-1:0]   wr_data,
    output logic                    rd_valid,
    output logic [WORD_WIDTH-1:0]   rd_data,
    output logic                    misalign_fault
);
    localparam int BYTES = WORD_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int IDXW  = $clog2(MEM_DEPTH_WORDS);
    localparam int CNTW  = OFFW + 2;

    typedef enum logic {IDLE, SECOND} state_e;
    state_e state_q, state_d;

    logic [OFFW-1:0]       off_q;
    logic [IDXW-1:0]       idx_q;
    logic                  rd_q, wr_q, sext_q, cross_q;
    logic [BYTES-1:0]      ben_q;
    logic [WORD_WIDTH-1:0] wdata_q, lo_q, rdata_q, ram_q;
    logic                  rd_pend_q, fault_q;

    logic [WORD_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

    function automatic logic [CNTW-1:0] popcnt(input logic [BYTES-1:0] v);
        logic [CNTW-1:0] n;
        n = '0;
        for (int i = 0; i < BYTES; i++) n = n + CNTW'(v[i]);
        return n;
    endfunction

    logic [OFFW-1:0] off_in;
    logic [IDXW-1:0] idx_in;
    logic            rd_in, wr_in, cross_in, accept, go, unused_adrs_hi;

    assign off_in         = adrs[OFFW-1:0];
    assign idx_in         = adrs[OFFW +: IDXW];
    assign unused_adrs_hi = ^adrs[ADRS_WIDTH-1:OFFW+IDXW];
    assign wr_in          = wren;
    assign rd_in          = rden && !wren;
    assign cross_in       = (CNTW'(off_in) + popcnt(byt_en)) > CNTW'(BYTES);
    assign accept         = req_valid && req_ready && !rst;
    assign go             = accept && (rd_in || wr_in) && (!cross_in || SPLIT_MISALIGNED);

    logic [2*BYTES-1:0]      ben_wide;
    logic [2*WORD_WIDTH-1:0] wdata_wide;
    logic [IDXW-1:0]         ram_idx;
    logic [BYTES-1:0]        ram_we;
    logic [WORD_WIDTH-1:0]   ram_wdata;
    logic                    ram_rd;

    // Data and lane mask are shifted into a two-word window: low half is beat 0, high half beat 1.
    always_comb begin
        state_d   = state_q;
        req_ready = (state_q == IDLE);
        ram_we    = '0;
        ram_rd    = 1'b0;
        if (state_q == IDLE) begin
            ram_idx    = idx_in;
            ben_wide   = {{BYTES{1'b0}}, byt_en} << off_in;
            wdata_wide = {{WORD_WIDTH{1'b0}}, wr_data} << (8 * off_in);
            ram_wdata  = wdata_wide[WORD_WIDTH-1:0];
            if (go) begin
                if (wr_in) ram_we = ben_wide[BYTES-1:0];
                else       ram_rd = 1'b1;
                if (cross_in) state_d = SECOND;
            end
        end else begin
            ram_idx    = idx_q + IDXW'(1);
            ben_wide   = {{BYTES{1'b0}}, ben_q} << off_q;
            wdata_wide = {{WORD_WIDTH{1'b0}}, wdata_q} << (8 * off_q);
            ram_wdata  = wdata_wide[2*WORD_WIDTH-1:WORD_WIDTH];
            if (!rst) begin
                if (wr_q) ram_we = ben_wide[2*BYTES-1:BYTES];
                else      ram_rd = 1'b1;
            end
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++)
            if (ram_we[b]) mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
        if (ram_rd) ram_q <= mem[ram_idx];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            off_q   <= off_in;
            idx_q   <= idx_in;
            rd_q    <= rd_in;
            wr_q    <= wr_in;
            ben_q   <= byt_en;
            sext_q  <= sign_ext;
            wdata_q <= wr_data;
            cross_q <= cross_in;
        end
        if (state_q == SECOND) lo_q <= ram_q;
    end

    logic [2*WORD_WIDTH-1:0] merge_cat;
    logic [WORD_WIDTH-1:0]   merged, rd_ext;
    logic                    sign;

    always_comb begin
        merge_cat = {ram_q, cross_q ? lo_q : ram_q};
        merged    = merge_cat[8*off_q +: WORD_WIDTH];
        sign      = 1'b0;
        rd_ext    = '0;
        for (int b = 0; b < BYTES; b++)
            if (ben_q[b]) sign = merged[8*b+7];
        for (int b = 0; b < BYTES; b++)
            rd_ext[8*b +: 8] = ben_q[b] ? merged[8*b +: 8] : {8{sext_q & sign}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_pend_q <= 1'b0;
            fault_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= (go && rd_in && !cross_in) || (state_q == SECOND && rd_q);
            fault_q   <= accept && (rd_in || wr_in) && cross_in && !SPLIT_MISALIGNED;
            if (rd_pend_q) rdata_q <= rd_ext;
        end
    end

    // A reset landing on the response cycle must hide that response immediately.
    assign rd_valid       = rd_pend_q && !rst;
    assign rd_data        = rst ? '0 : (rd_pend_q ? rd_ext : rdata_q);
    assign misalign_fault = fault_q;
endmodule

// File: tb/tb_d_mem_ctrl.sv
// Bench for d_mem_ctrl: a split and a rejecting instance share one request stream and are
// compared each cycle against a byte-addressed memory model, plus literal directed checks.
module tb_d_mem_ctrl;
    localparam int TOT = 1024;

    logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, rden = 1'b0, wren = 1'b0, sign_ext = 1'b0;
    logic [31:0] adrs = '0, wr_data = '0;
    logic [3:0]  byt_en = '0;
    logic        d_ready, d_rv, d_f, z_ready, z_rv, z_f;
    logic [31:0] d_rd, z_rd;
    int          n_tests = 0, n_fail = 0;
    bit          chk_en = 1'b0;

    d_mem_ctrl #(.WORD_WIDTH(32), .ADRS_WIDTH(32), .MEM_DEPTH_WORDS(256), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d_ready), .adrs(adrs),
        .rden(rden), .wren(wren), .byt_en(byt_en), .sign_ext(sign_ext), .wr_data(wr_data),
        .rd_valid(d_rv), .rd_data(d_rd), .misalign_fault(d_f));

    d_mem_ctrl #(.WORD_WIDTH(32), .ADRS_WIDTH(32), .MEM_DEPTH_WORDS(256), .SPLIT_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(z_ready), .adrs(adrs),
        .rden(rden), .wren(wren), .byt_en(byt_en), .sign_ext(sign_ext), .wr_data(wr_data),
        .rd_valid(z_rv), .rd_data(z_rd), .misalign_fault(z_f));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Model memory: index 0 = splitting instance, 1 = rejecting instance.
    logic [7:0] mm [2][TOT];

    function automatic logic [31:0] m_read(input int i, input logic [9:0] a, input int sz, input logic sx);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = mm[i][(int'(a) + k) % TOT];
        if (sx && sz < 4 && v[8*sz-1])
            for (int k = 8*sz; k < 32; k++) v[k] = 1'b1;
        return v;
    endfunction

    task automatic m_write(input int i, input logic [9:0] a, input int sz, input logic [31:0] d);
        for (int k = 0; k < sz; k++) mm[i][(int'(a) + k) % TOT] = d[8*k +: 8];
    endtask

    bit          m_ready, m_rv, m_sec, m_p2, m0_rv, m0_f;
    logic [31:0] m_rd, m_p2d, m0_rd;

    initial begin
        int  sz;
        bit  cr, do_wr, do_rd;
        m_ready = 1; m_rv = 0; m_rd = '0; m_sec = 0; m_p2 = 0; m_p2d = '0;
        m0_rv = 0; m0_rd = '0; m0_f = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_ready = 1; m_rv = 0; m_rd = '0; m_sec = 0; m_p2 = 0;
                m0_rv = 0; m0_rd = '0; m0_f = 0;
            end else begin
                m_rv = 0; m0_rv = 0; m0_f = 0;
                if (m_sec) begin
                    m_sec = 0; m_ready = 1;
                    if (m_p2) begin m_rv = 1; m_rd = m_p2d; m_p2 = 0; end
                end else if (req_valid) begin
                    sz    = $countones(byt_en);
                    cr    = (int'(adrs[1:0]) + sz) > 4;
                    do_wr = wren;
                    do_rd = rden && !wren;
                    if (do_wr) m_write(0, adrs[9:0], sz, wr_data);
                    if (do_rd) begin
                        if (cr) begin m_p2 = 1; m_p2d = m_read(0, adrs[9:0], sz, sign_ext); end
                        else begin m_rv = 1; m_rd = m_read(0, adrs[9:0], sz, sign_ext); end
                    end
                    if ((do_wr || do_rd) && cr) begin m_sec = 1; m_ready = 0; m0_f = 1; end
                    else begin
                        if (do_wr) m_write(1, adrs[9:0], sz, wr_data);
                        if (do_rd) begin m0_rv = 1; m0_rd = m_read(1, adrs[9:0], sz, sign_ext); end
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en && !rst) begin
            chk("ready", 32'(d_ready), 32'(m_ready));
            chk("rd_valid", 32'(d_rv), 32'(m_rv));
            chk("rd_data", d_rd, m_rd);
            chk("fault", 32'(d_f), 32'd0);
            chk("z_ready", 32'(z_ready), 32'd1);
            chk("z_rd_valid", 32'(z_rv), 32'(m0_rv));
            chk("z_rd_data", z_rd, m0_rd);
            chk("z_fault", 32'(z_f), 32'(m0_f));
        end
    end

    // Called #1 after a posedge; returns #1 after the accepting edge with inputs scrambled.
    task automatic send(input logic [31:0] a, input logic r, input logic w, input logic [3:0] be,
                        input logic sx, input logic [31:0] d);
        int g;
        g = 0;
        while (!d_ready && g < 8) begin @(posedge clk); #1; g++; end
        if (g == 8) chk("ready timeout", 32'(d_ready), 32'd1);
        adrs = a; rden = r; wren = w; byt_en = be; sign_ext = sx; wr_data = d; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        adrs = $urandom; wr_data = $urandom; byt_en = 4'($urandom);
        sign_ext = 1'($urandom); rden = 1'($urandom); wren = 1'($urandom);
    endtask

    task automatic rd_lit(input string nm, input logic [31:0] a, input logic [3:0] be, input logic sx,
                          input int lat, input logic [31:0] mask, input logic [31:0] exp);
        int c;
        send(a, 1'b1, 1'b0, be, sx, '0);
        c = 1;
        while (!d_rv && c < 5) begin @(posedge clk); #1; c++; end
        chk({nm, " latency"}, 32'(c), 32'(lat));
        chk(nm, d_rd & mask, exp);
    endtask

    initial begin
        logic [31:0] a;
        int          op, s;
        logic [3:0]  be;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        chk("rst ready", 32'(d_ready), 32'd1);
        chk("rst rd_valid", 32'(d_rv), 32'd0);
        chk("rst rd_data", d_rd, 32'd0);
        chk("rst fault", 32'(d_f), 32'd0);
        chk("rst z_fault", 32'(z_f), 32'd0);

        for (int w = 0; w < 256; w++) send(32'(w * 4), 1'b0, 1'b1, 4'hF, 1'b0, $urandom);

        send(32'h100, 1'b0, 1'b1, 4'hF, 1'b0, 32'hDEADBEEF);
        chk("b2b ready", 32'(d_ready), 32'd1);
        rd_lit("word 0x100", 32'h100, 4'hF, 1'b0, 1, 32'hFFFFFFFF, 32'hDEADBEEF);
        rd_lit("byte 0x103 sx", 32'h103, 4'h1, 1'b1, 1, 32'hFFFFFFFF, 32'hFFFFFFDE);
        rd_lit("byte 0x103 zx", 32'h103, 4'h1, 1'b0, 1, 32'hFFFFFFFF, 32'h000000DE);
        rd_lit("half 0x102 sx", 32'h102, 4'h3, 1'b1, 1, 32'hFFFFFFFF, 32'hFFFFDEAD);

        send(32'h107, 1'b0, 1'b1, 4'h3, 1'b0, 32'h1234);
        chk("xwrite ready low", 32'(d_ready), 32'd0);
        @(posedge clk); #1;
        chk("xwrite ready back", 32'(d_ready), 32'd1);
        rd_lit("word 0x104 b3", 32'h104, 4'hF, 1'b0, 1, 32'hFF000000, 32'h34000000);
        rd_lit("word 0x108 b0", 32'h108, 4'hF, 1'b0, 1, 32'h000000FF, 32'h00000012);
        rd_lit("xhalf 0x107", 32'h107, 4'h3, 1'b1, 2, 32'hFFFFFFFF, 32'h00001234);

        send(32'h3FE, 1'b0, 1'b1, 4'hF, 1'b0, 32'hAABBCCDD);
        rd_lit("wrap word255", 32'h3FC, 4'hF, 1'b0, 1, 32'hFFFF0000, 32'hCCDD0000);
        rd_lit("wrap word0", 32'h000, 4'hF, 1'b0, 1, 32'h0000FFFF, 32'h0000AABB);
        rd_lit("wrap read 0x3FE", 32'h3FE, 4'hF, 1'b0, 2, 32'hFFFFFFFF, 32'hAABBCCDD);

        send(32'h101, 1'b1, 1'b0, 4'hF, 1'b0, '0);
        chk("z fault at T+1", 32'(z_f), 32'd1);
        chk("z no rd_valid", 32'(z_rv), 32'd0);
        @(posedge clk); #1;
        chk("z fault pulse", 32'(z_f), 32'd0);

        for (int t = 0; t < 600; t++) begin
            a  = $urandom;
            op = $urandom_range(0, 19);
            s  = $urandom_range(0, 2);
            be = (s == 0) ? 4'h1 : (s == 1) ? 4'h3 : 4'hF;
            if (t % 16 == 0) a[9:2] = 8'hFF;
            if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
            send(a, (op <= 8) || (op == 18), (op >= 9) && (op <= 18), be, 1'($urandom), $urandom);
        end
        @(posedge clk); #1;

        send(32'h100, 1'b1, 1'b0, 4'hF, 1'b0, '0);
        rst = 1'b1;
        #1;
        chk("rst on response rd_valid", 32'(d_rv), 32'd0);
        chk("rst on response rd_data", d_rd, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        chk("rst on response ready", 32'(d_ready), 32'd1);

        send(32'h201, 1'b1, 1'b0, 4'hF, 1'b0, '0);
        chk("second ready low", 32'(d_ready), 32'd0);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        chk("rst in second ready", 32'(d_ready), 32'd1);
        chk("rst in second rd_data", d_rd, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst in second no rd_valid", 32'(d_rv), 32'd0);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "simulation time limit reached");
    end
endmodule
